mem_arbiter: RTL

- Shares one 128-bit-block main memory between the instruction cache (read-only port) and the data cache (read/write port).
- Sits between both cache controllers and the memory model, and replaces their direct memory connections.
- Grants one requester per transaction with round-robin tie-breaking, and latches the address, write data and read block.
- Drives per-requester busywait handshakes that match the existing cache-controller protocol: request held high until busywait falls for one cycle.

---
 rtl/mem_arbiter_pkg.sv | 21 ++
 rtl/mem_arbiter_rr_arbiter2.sv | 20 ++
 rtl/mem_arbiter.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared encodings for the two-port main-memory arbiter.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StWait,
        StDone
    } state_e;

    typedef enum logic {
        OwnIcache = 1'b0,
        OwnDcache = 1'b1
    } owner_e;

    typedef enum logic {
        OpRd = 1'b0,
        OpWr = 1'b1
    } op_e;

endpackage

// File: rtl/mem_arbiter_rr_arbiter2.sv
// Two-input round-robin picker: on a tie, the requester that did not win last time is chosen.
module rr_arbiter2
    import mem_arbiter_pkg::*;
(
    input  logic   req_i,
    input  logic   req_d,
    input  owner_e last_grant,
    output owner_e grant
);

    always_comb begin
        grant = OwnIcache;
        if (req_i && req_d) begin
            grant = (last_grant == OwnIcache) ? OwnDcache : OwnIcache;
        end else if (req_d) begin
            grant = OwnDcache;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one block-wide main memory between the icache (read-only) and dcache (read/write),
// one transaction at a time, with per-requester busywait handshakes.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W  = 6,
    parameter int unsigned BLOCK_W = 128,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               i_read,
    input  logic [ADDR_W-1:0]  i_address,
    output logic [BLOCK_W-1:0] i_readdata,
    output logic               i_busywait,
    input  logic               d_read,
    input  logic               d_write,
    input  logic [ADDR_W-1:0]  d_address,
    input  logic [BLOCK_W-1:0] d_writedata,
    output logic [BLOCK_W-1:0] d_readdata,
    output logic               d_busywait,
    output logic               mem_read,
    output logic               mem_write,
    output logic [ADDR_W-1:0]  mem_address,
    output logic [BLOCK_W-1:0] mem_writedata,
    input  logic [BLOCK_W-1:0] mem_readdata,
    input  logic               mem_busywait,
    output logic               timeout_err
);

    // One spare count value so the width is never zero when the check is disabled.
    localparam int unsigned     CNT_W       = $clog2(TIMEOUT + 2);
    localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);

    state_e             state_q, state_d;
    owner_e             owner_q, owner_d;
    owner_e             last_q, last_d;
    op_e                op_q, op_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [BLOCK_W-1:0] wdata_q, wdata_d;
    logic [BLOCK_W-1:0] rdata_q, rdata_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               err_q, err_d;

    logic   d_req;
    owner_e grant;

    assign d_req = d_read | d_write;

    rr_arbiter2 u_rr (
        .req_i      (i_read),
        .req_d      (d_req),
        .last_grant (last_q),
        .grant      (grant)
    );

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        last_d    = last_q;
        op_d      = op_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        cnt_d     = cnt_q;
        err_d     = err_q;
        mem_read  = 1'b0;
        mem_write = 1'b0;

        case (state_q)
            StIdle: begin
                if (i_read || d_req) begin
                    owner_d = grant;
                    state_d = StIssue;
                    if (grant == OwnDcache) begin
                        addr_d  = d_address;
                        wdata_d = d_writedata;
                        // A simultaneous read+write from the dcache is a write-back.
                        op_d    = d_write ? OpWr : OpRd;
                    end else begin
                        addr_d = i_address;
                        op_d   = OpRd;
                    end
                end
            end
            StIssue: begin
                // mem_busywait is still stale here, so it is not looked at.
                mem_read  = (op_q == OpRd);
                mem_write = (op_q == OpWr);
                cnt_d     = '0;
                state_d   = StWait;
            end
            StWait: begin
                mem_read  = (op_q == OpRd);
                mem_write = (op_q == OpWr);
                if (!mem_busywait) begin
                    if (op_q == OpRd) begin
                        rdata_d = mem_readdata;
                    end
                    last_d  = owner_q;
                    state_d = StDone;
                end else begin
                    if (cnt_q != TIMEOUT_CNT) begin
                        cnt_d = cnt_q + 1'b1;
                    end
                    if (TIMEOUT != 0 && cnt_d == TIMEOUT_CNT) begin
                        err_d = 1'b1;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= StIdle;
            owner_q <= OwnIcache;
            last_q  <= OwnIcache;
            op_q    <= OpRd;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    assign mem_address   = addr_q;
    assign mem_writedata = wdata_q;
    assign timeout_err   = err_q;

    assign i_readdata = rdata_q;
    assign d_readdata = rdata_q;

    assign i_busywait = i_read & ~((state_q == StDone) && (owner_q == OwnIcache));
    assign d_busywait = d_req & ~((state_q == StDone) && (owner_q == OwnDcache));

endmodule
